// File: rtl/natv_gpio_pkg.sv
// rtl/natv_gpio_pkg.sv - register map and interrupt encodings for natv_gpio
//
// Purpose: shared constants for the native-bus GPIO controller.
//   - Register byte offsets within the decoded address window.
//   - Interrupt type encoding (one bit per pin in IRQ_TYPE).
//   - Helper that expands byte strobes into a 32-bit bit mask.
package natv_gpio_pkg;

    localparam logic [7:0] GPIO_OUT_OFS   = 8'h00;
    localparam logic [7:0] GPIO_IN_OFS    = 8'h04;
    localparam logic [7:0] GPIO_OEN_OFS   = 8'h08;
    localparam logic [7:0] GPIO_PUN_OFS   = 8'h0C;
    localparam logic [7:0] GPIO_PDN_OFS   = 8'h10;
    localparam logic [7:0] GPIO_SET_OFS   = 8'h14;
    localparam logic [7:0] GPIO_CLR_OFS   = 8'h18;
    localparam logic [7:0] GPIO_TGL_OFS   = 8'h1C;
    localparam logic [7:0] GPIO_EN_OFS    = 8'h20;
    localparam logic [7:0] GPIO_TYPE_OFS  = 8'h24;
    localparam logic [7:0] GPIO_POL_OFS   = 8'h28;
    localparam logic [7:0] GPIO_BOTH_OFS  = 8'h2C;
    localparam logic [7:0] GPIO_PEND_OFS  = 8'h30;

    localparam logic IRQ_TYPE_LEVEL = 1'b0;
    localparam logic IRQ_TYPE_EDGE  = 1'b1;

    // Byte lane k enables bits [8k+7:8k].
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            m[8*k +: 8] = {8{strb[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/nmi_if.sv
// rtl/nmi_if.sv - native memory-mapped bus interface
//
// Purpose: single-beat request/acknowledge bus shared by native peripherals.
//   valid  master holds a request
//   addr   byte address (slave decodes the low bits)
//   wdata  write data
//   wstrb  byte strobes; all-zero means read
//   rdata  registered read data, valid while ready is high
//   ready  one-cycle acknowledge pulse from the slave
interface nmi_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;

    modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
    modport master (output valid, addr, wdata, wstrb, input rdata, ready);
endinterface

// File: rtl/natv_gpio_sync.sv
// rtl/natv_gpio_sync.sv - multi-stage input synchroniser for the GPIO pads
//
// Purpose: brings asynchronous pad inputs into the clk_i domain.
// Ports:
//   clk_i  system clock
//   rst_i  synchronous reset, active-high; clears every stage
//   d_i    asynchronous pad values
//   q_o    synchronised values (last stage)
module natv_gpio_sync #(
    parameter int NUM_PINS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_PINS-1:0] d_i,
    output logic [NUM_PINS-1:0] q_o
);

    logic [NUM_PINS-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/natv_gpio.sv
// rtl/natv_gpio.sv - native-bus GPIO controller with per-pin interrupts
//
// Purpose: register file, bus decode and interrupt logic for up to 32 pads.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous reset, active-high
//   nmi         native bus slave (valid/addr/wdata/wstrb in, rdata/ready out)
//   gpio_out_o  pad output value
//   gpio_in_i   asynchronous pad input
//   gpio_oen_o  output enable, active-low
//   gpio_pun_o  pull-up enable, active-low
//   gpio_pdn_o  pull-down enable, active-low
//   irq_o       OR of pending & enabled interrupts
module natv_gpio
    import natv_gpio_pkg::*;
#(
    parameter int NUM_PINS    = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    nmi_if.slave                nmi,
    output logic [NUM_PINS-1:0] gpio_out_o,
    input  logic [NUM_PINS-1:0] gpio_in_i,
    output logic [NUM_PINS-1:0] gpio_oen_o,
    output logic [NUM_PINS-1:0] gpio_pun_o,
    output logic [NUM_PINS-1:0] gpio_pdn_o,
    output logic                irq_o
);

    typedef logic [NUM_PINS-1:0] pins_t;

    pins_t out_q,  out_d;
    pins_t oen_q,  oen_d;
    pins_t pun_q,  pun_d;
    pins_t pdn_q,  pdn_d;
    pins_t en_q,   en_d;
    pins_t type_q, type_d;
    pins_t pol_q,  pol_d;
    pins_t both_q, both_d;
    pins_t pend_q, pend_d;
    pins_t prev_q, prev_d;

    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;

    pins_t       in_s;
    pins_t       rise, fall, evt;
    pins_t       lane_mask, wbits, w1c_mask;
    logic [31:0] strb_mask;
    logic [31:0] rd_val;
    logic [ADDR_W-1:0] ofs;
    logic        wr_en;

    // Address bits above ADDR_W and data bits above NUM_PINS are don't-care.
    logic unused_bus;
    assign unused_bus = ^{nmi.addr, nmi.wdata};

    natv_gpio_sync #(
        .NUM_PINS    (NUM_PINS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (gpio_in_i),
        .q_o   (in_s)
    );

    // A request is acknowledged on the cycle after valid is seen while ready
    // is low, so holding valid produces one access every two cycles.
    assign ready_d   = nmi.valid & ~ready_q;
    assign ofs       = nmi.addr[ADDR_W-1:0];
    assign wr_en     = |nmi.wstrb;
    assign strb_mask = strb_to_mask(nmi.wstrb);
    assign lane_mask = strb_mask[NUM_PINS-1:0];
    assign wbits     = nmi.wdata[NUM_PINS-1:0] & lane_mask;

    assign rise = in_s & ~prev_q;
    assign fall = ~in_s & prev_q;

    always_comb begin
        evt = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            if (en_q[i]) begin
                if (type_q[i] == IRQ_TYPE_LEVEL) begin
                    evt[i] = pol_q[i] ? in_s[i] : ~in_s[i];
                end else if (both_q[i]) begin
                    evt[i] = rise[i] | fall[i];
                end else begin
                    evt[i] = pol_q[i] ? rise[i] : fall[i];
                end
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (ofs)
            ADDR_W'(GPIO_OUT_OFS):  rd_val = 32'(out_q);
            ADDR_W'(GPIO_IN_OFS):   rd_val = 32'(in_s);
            ADDR_W'(GPIO_OEN_OFS):  rd_val = 32'(oen_q);
            ADDR_W'(GPIO_PUN_OFS):  rd_val = 32'(pun_q);
            ADDR_W'(GPIO_PDN_OFS):  rd_val = 32'(pdn_q);
            ADDR_W'(GPIO_EN_OFS):   rd_val = 32'(en_q);
            ADDR_W'(GPIO_TYPE_OFS): rd_val = 32'(type_q);
            ADDR_W'(GPIO_POL_OFS):  rd_val = 32'(pol_q);
            ADDR_W'(GPIO_BOTH_OFS): rd_val = 32'(both_q);
            ADDR_W'(GPIO_PEND_OFS): rd_val = 32'(pend_q);
            default:                rd_val = '0;
        endcase
    end

    always_comb begin
        out_d    = out_q;
        oen_d    = oen_q;
        pun_d    = pun_q;
        pdn_d    = pdn_q;
        en_d     = en_q;
        type_d   = type_q;
        pol_d    = pol_q;
        both_d   = both_q;
        rdata_d  = rdata_q;
        w1c_mask = '0;

        if (ready_d) begin
            rdata_d = rd_val;
            if (wr_en) begin
                case (ofs)
                    ADDR_W'(GPIO_OUT_OFS):  out_d  = (out_q  & ~lane_mask) | wbits;
                    ADDR_W'(GPIO_OEN_OFS):  oen_d  = (oen_q  & ~lane_mask) | wbits;
                    ADDR_W'(GPIO_PUN_OFS):  pun_d  = (pun_q  & ~lane_mask) | wbits;
                    ADDR_W'(GPIO_PDN_OFS):  pdn_d  = (pdn_q  & ~lane_mask) | wbits;
                    ADDR_W'(GPIO_SET_OFS):  out_d  = out_q | wbits;
                    ADDR_W'(GPIO_CLR_OFS):  out_d  = out_q & ~wbits;
                    ADDR_W'(GPIO_TGL_OFS):  out_d  = out_q ^ wbits;
                    ADDR_W'(GPIO_EN_OFS):   en_d   = (en_q   & ~lane_mask) | wbits;
                    ADDR_W'(GPIO_TYPE_OFS): type_d = (type_q & ~lane_mask) | wbits;
                    ADDR_W'(GPIO_POL_OFS):  pol_d  = (pol_q  & ~lane_mask) | wbits;
                    ADDR_W'(GPIO_BOTH_OFS): both_d = (both_q & ~lane_mask) | wbits;
                    ADDR_W'(GPIO_PEND_OFS): w1c_mask = wbits;
                    default: ;
                endcase
            end
        end

        // A fresh event outranks a clear landing on the same edge.
        pend_d = (pend_q & ~w1c_mask) | evt;
        prev_d = in_s;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q   <= '0;
            oen_q   <= '1;
            pun_q   <= '1;
            pdn_q   <= '1;
            en_q    <= '0;
            type_q  <= '0;
            pol_q   <= '0;
            both_q  <= '0;
            pend_q  <= '0;
            prev_q  <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            out_q   <= out_d;
            oen_q   <= oen_d;
            pun_q   <= pun_d;
            pdn_q   <= pdn_d;
            en_q    <= en_d;
            type_q  <= type_d;
            pol_q   <= pol_d;
            both_q  <= both_d;
            pend_q  <= pend_d;
            prev_q  <= prev_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    assign nmi.ready  = ready_q;
    assign nmi.rdata  = rdata_q;
    assign gpio_out_o = out_q;
    assign gpio_oen_o = oen_q;
    assign gpio_pun_o = pun_q;
    assign gpio_pdn_o = pdn_q;
    assign irq_o      = |(pend_q & en_q);

endmodule

// File: tb/tb_natv_gpio.sv
// tb/tb_natv_gpio.sv - self-checking bench for natv_gpio
module tb_natv_gpio;

    localparam int          NP = 16;
    localparam int          SS = 2;
    localparam logic [31:0] PM = 32'h0000_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] pad = '0;
    logic [NP-1:0] gout, goen, gpun, gpdn;
    logic          irq;

    nmi_if bus ();

    natv_gpio #(
        .NUM_PINS    (NP),
        .SYNC_STAGES (SS),
        .ADDR_W      (8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .nmi        (bus),
        .gpio_out_o (gout),
        .gpio_in_i  (pad),
        .gpio_oen_o (goen),
        .gpio_pun_o (gpun),
        .gpio_pdn_o (gpdn),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: register values, pad history and pending bits.
    bit [31:0] m_out, m_oen, m_pun, m_pdn, m_en, m_type, m_pol, m_both, m_pend;
    bit [31:0] m_prev, m_rdata;
    bit        m_ready;
    bit [31:0] pad_hist[$];

    function automatic bit [31:0] sync_view();
        if (pad_hist.size() >= SS) return pad_hist[SS-1];
        return 32'h0;
    endfunction

    function automatic bit [31:0] model_read(input bit [7:0] a, input bit [31:0] ins);
        case (a)
            8'h00: return m_out;
            8'h04: return ins;
            8'h08: return m_oen;
            8'h0C: return m_pun;
            8'h10: return m_pdn;
            8'h20: return m_en;
            8'h24: return m_type;
            8'h28: return m_pol;
            8'h2C: return m_both;
            8'h30: return m_pend;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit [31:0] ins, evt, mask, d, w1c;
        bit        rise, fall, acc;
        if (rst) begin
            m_out = 0; m_oen = PM; m_pun = PM; m_pdn = PM;
            m_en = 0; m_type = 0; m_pol = 0; m_both = 0; m_pend = 0;
            m_prev = 0; m_rdata = 0; m_ready = 0;
            pad_hist.delete();
        end else begin
            ins = sync_view();
            evt = 0;
            for (int i = 0; i < NP; i++) begin
                rise = ins[i] && !m_prev[i];
                fall = !ins[i] && m_prev[i];
                if (m_en[i]) begin
                    if (!m_type[i])     evt[i] = m_pol[i] ? ins[i] : !ins[i];
                    else if (m_both[i]) evt[i] = rise || fall;
                    else                evt[i] = m_pol[i] ? rise : fall;
                end
            end
            w1c = 0;
            acc = bus.valid && !m_ready;
            if (acc) begin
                m_rdata = model_read(bus.addr[7:0], ins);
                if (bus.wstrb != 0) begin
                    mask = 0;
                    for (int k = 0; k < 4; k++) if (bus.wstrb[k]) mask[8*k +: 8] = 8'hFF;
                    mask = mask & PM;
                    d = bus.wdata & mask;
                    case (bus.addr[7:0])
                        8'h00: m_out  = (m_out  & ~mask) | d;
                        8'h08: m_oen  = (m_oen  & ~mask) | d;
                        8'h0C: m_pun  = (m_pun  & ~mask) | d;
                        8'h10: m_pdn  = (m_pdn  & ~mask) | d;
                        8'h14: m_out  = m_out | d;
                        8'h18: m_out  = m_out & ~d;
                        8'h1C: m_out  = m_out ^ d;
                        8'h20: m_en   = (m_en   & ~mask) | d;
                        8'h24: m_type = (m_type & ~mask) | d;
                        8'h28: m_pol  = (m_pol  & ~mask) | d;
                        8'h2C: m_both = (m_both & ~mask) | d;
                        8'h30: w1c    = d;
                        default: ;
                    endcase
                end
            end
            m_pend  = (m_pend & ~w1c) | evt;
            m_ready = acc;
            m_prev  = ins;
            pad_hist.push_front(32'(pad));
            if (pad_hist.size() > SS) void'(pad_hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_out",   32'(gout),  m_out);
            check("cyc_oen",   32'(goen),  m_oen);
            check("cyc_pun",   32'(gpun),  m_pun);
            check("cyc_pdn",   32'(gpdn),  m_pdn);
            check("cyc_irq",   32'(irq),   32'(|(m_pend & m_en)));
            check("cyc_ready", 32'(bus.ready), 32'(m_ready));
            if (m_ready) check("cyc_rdata", bus.rdata, m_rdata);
        end
    end

    // Called at a negedge; returns at a negedge with one idle cycle done.
    task automatic access(input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
        int lat;
        lat = 0;
        bus.valid = 1'b1; bus.addr = {24'h0, a}; bus.wdata = d; bus.wstrb = s;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.ready !== 1'b1 && lat < 8);
        check("ready_latency", 32'(lat), 32'd1);
        rd = bus.rdata;
        bus.valid = 1'b0; bus.wstrb = 4'h0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] junk;
        access(a, d, 4'hF, junk);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] v;
        access(a, 32'h0, 4'h0, v);
        check(name, v, exp);
    endtask

    initial begin
        logic [31:0] junk;
        bus.valid = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wstrb = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_ready", 32'(bus.ready), 32'h0);
        check("rst_irq",   32'(irq),       32'h0);
        rst = 1'b0;
        @(negedge clk);
        rd_chk("rst_oen",  8'h08, 32'h0000_FFFF);
        rd_chk("rst_out",  8'h00, 32'h0);
        rd_chk("rst_in",   8'h04, 32'h0);
        rd_chk("rst_pend", 8'h30, 32'h0);

        // Atomic output operations
        wr(8'h00, 32'h00F0);
        wr(8'h14, 32'h000F); check("set", 32'(gout), 32'h00FF);
        wr(8'h18, 32'h00F0); check("clr", 32'(gout), 32'h000F);
        wr(8'h1C, 32'h0101); check("tgl", 32'(gout), 32'h010E);
        rd_chk("set_reads_0", 8'h14, 32'h0);

        // Byte lanes and out-of-range bits
        wr(8'h00, 32'h0);
        access(8'h00, 32'hABCD, 4'b0010, junk);
        rd_chk("lane1", 8'h00, 32'hAB00);
        wr(8'h00, 32'hFFFF_FFFF);
        rd_chk("wide_out", 8'h00, 32'h0000_FFFF);

        // Unmapped offset still acknowledges and reads 0
        wr(8'h40, 32'hFFFF);
        rd_chk("unmapped", 8'h40, 32'h0);

        // Rising-edge interrupt on pin 3
        wr(8'h24, 32'h8);
        wr(8'h28, 32'h8);
        wr(8'h20, 32'h8);
        pad[3] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rise_irq_early", 32'(irq), 32'h0);
        @(negedge clk);
        check("rise_irq_3edges", 32'(irq), 32'h1);
        rd_chk("rise_pend", 8'h30, 32'h8);
        rd_chk("in_pin3",   8'h04, 32'h8);
        pad[3] = 1'b0;
        repeat (5) @(negedge clk);
        wr(8'h30, 32'h8);
        rd_chk("fall_no_event", 8'h30, 32'h0);
        check("w1c_irq", 32'(irq), 32'h0);

        // Level-low interrupt on pin 0
        wr(8'h20, 32'h1);
        repeat (2) @(negedge clk);
        wr(8'h30, 32'h1);
        rd_chk("level_reassert", 8'h30, 32'h1);
        pad[0] = 1'b1;
        repeat (4) @(negedge clk);
        wr(8'h30, 32'h1);
        rd_chk("level_released", 8'h30, 32'h0);

        // Both-edge pin 5, event coinciding with W1C
        wr(8'h24, 32'h20);
        wr(8'h2C, 32'h20);
        wr(8'h20, 32'h20);
        pad[5] = 1'b1;
        repeat (4) @(negedge clk);
        rd_chk("both_rise", 8'h30, 32'h20);
        pad[5] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr(8'h30, 32'h20);
        rd_chk("set_beats_clr", 8'h30, 32'h20);
        wr(8'h30, 32'h20);
        rd_chk("both_cleared", 8'h30, 32'h0);

        // Reset in the middle of an access
        wr(8'h08, 32'h1234);
        wr(8'h0C, 32'h00FF);
        bus.valid = 1'b1; bus.addr = 32'h0; bus.wstrb = 4'h0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(bus.ready), 32'h0);
        @(negedge clk);
        rst = 1'b0; bus.valid = 1'b0;
        @(negedge clk);
        rd_chk("midrst_oen", 8'h08, 32'h0000_FFFF);
        rd_chk("midrst_pun", 8'h0C, 32'h0000_FFFF);
        rd_chk("midrst_out", 8'h00, 32'h0);
        rd_chk("midrst_en",  8'h20, 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
